// File: rtl/spi_burst_reg_slave.sv
// SPI slave with selectable CPOL/CPHA, a command word (rw + address) and
// auto-incrementing burst register reads/writes. All pins are oversampled in clk_i.
module spi_burst_reg_slave #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        spi_mode_i,
    input  logic              sclk_i,
    input  logic              ss_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    output logic              reg_wr_en_o,
    output logic [ADDR_W-1:0] reg_wr_addr_o,
    output logic [DATA_W-1:0] reg_wr_data_o,
    output logic [ADDR_W-1:0] reg_rd_addr_o,
    input  logic [DATA_W-1:0] reg_rd_data_i,
    output logic              busy_o,
    output logic              frame_err_o
);

    localparam int unsigned CntW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {StWaitSsHigh, StIdle, StCmd, StData} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, ss_prev_q;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic                   sample_edge, shift_edge, ss_rise, ss_fall, last_bit;
    logic [DATA_W-1:0]      rx_word;

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rw_q, rw_d, load_q, load_d, wr_en_q, wr_en_d;
    logic              busy_q, busy_d, oe_q, oe_d, ferr_q, ferr_d;

    // Synchronisers plus one extra sample of sclk/ss_n for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // ss_n reads as selected after reset so a frame in flight is never joined mid-way
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    // Edge classification against the latched mode
    always_comb begin
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        ss_s        = ss_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sclk_rise   = sclk_s & ~sclk_prev_q;
        sclk_fall   = ~sclk_s & sclk_prev_q;
        ss_rise     = ss_s & ~ss_prev_q;
        ss_fall     = ~ss_s & ss_prev_q;
        lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
        trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
        sample_edge = mode_q[0] ? trail_edge : lead_edge;
        shift_edge  = mode_q[0] ? lead_edge : trail_edge;
        last_bit    = (bit_cnt_q == CntW'(DATA_W - 1));
        rx_word     = {rx_sr_q[DATA_W-2:0], mosi_s};
    end

    // Next-state logic: frame FSM, shift registers and register-bus strobes
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        rx_sr_d   = rx_sr_q;
        tx_sr_d   = tx_sr_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        oe_d      = oe_q;
        load_d    = 1'b0;
        wr_en_d   = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            StWaitSsHigh: begin
                if (ss_s) state_d = StIdle;
            end
            StIdle: begin
                if (ss_s) mode_d = spi_mode_i;
                if (ss_fall) begin
                    state_d   = StCmd;
                    busy_d    = 1'b1;
                    oe_d      = 1'b1;
                    tx_sr_d   = '0;
                    bit_cnt_d = '0;
                    rw_d      = 1'b0;
                end
            end
            StCmd, StData: begin
                if (ss_rise) begin
                    // Deselect beats any sclk edge seen in the same cycle
                    busy_d = 1'b0;
                    oe_d   = 1'b0;
                    if (bit_cnt_q != '0) begin
                        ferr_d  = 1'b1;
                        state_d = StWaitSsHigh;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    if (load_q) tx_sr_d = reg_rd_data_i;
                    // Edge that would shift at a word boundary is skipped: MSB of the next
                    // word must stay on miso for the first sample.
                    if (shift_edge && bit_cnt_q != '0) tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                    if (sample_edge) begin
                        rx_sr_d = rx_word;
                        if (!last_bit) begin
                            bit_cnt_d = bit_cnt_q + CntW'(1);
                        end else begin
                            bit_cnt_d = '0;
                            if (state_q == StCmd) begin
                                state_d = StData;
                                rw_d    = rx_word[DATA_W-1];
                                addr_d  = rx_word[ADDR_W-1:0];
                                if (rx_word[DATA_W-1]) begin
                                    rd_addr_d = rx_word[ADDR_W-1:0];
                                    load_d    = 1'b1;
                                end
                            end else if (rw_q) begin
                                addr_d    = addr_q + ADDR_W'(1);
                                rd_addr_d = addr_q + ADDR_W'(1);
                                load_d    = 1'b1;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = addr_q;
                                wr_data_d = rx_word;
                                addr_d    = addr_q + ADDR_W'(1);
                            end
                        end
                    end
                end
            end
            default: state_d = StWaitSsHigh;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StWaitSsHigh;
            mode_q    <= 2'b00;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rw_q      <= 1'b0;
            load_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            oe_q      <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            rx_sr_q   <= rx_sr_d;
            tx_sr_q   <= tx_sr_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rw_q      <= rw_d;
            load_q    <= load_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            oe_q      <= oe_d;
            ferr_q    <= ferr_d;
        end
    end

    assign miso_o        = oe_q & tx_sr_q[DATA_W-1];
    assign miso_oe_o     = oe_q;
    assign reg_wr_en_o   = wr_en_q;
    assign reg_wr_addr_o = wr_addr_q;
    assign reg_wr_data_o = wr_data_q;
    assign reg_rd_addr_o = rd_addr_q;
    assign busy_o        = busy_q;
    assign frame_err_o   = ferr_q;

endmodule

// File: tb/tb_spi_burst_reg_slave.sv
// Self-checking bench: an SPI master task drives frames in all four modes; a
// register-array model predicts the write strobes and the MISO read data.
module tb_spi_burst_reg_slave;

    localparam int HALF = 8;  // sclk half period in clk cycles (f_sclk = f_clk/16)

    logic       clk;
    logic       rst;
    logic [1:0] spi_mode;
    logic       sclk, ss_n, mosi;
    logic       miso, miso_oe, reg_wr_en, busy, frame_err;
    logic [3:0] reg_wr_addr, reg_rd_addr;
    logic [7:0] reg_wr_data, reg_rd_data;

    int n_checks;
    int n_pass;

    // Register file the DUT talks to, plus the write log and error-pulse count
    bit         rf_init_q;
    logic [7:0] regfile [16];
    logic [11:0] wr_q [$];
    int         ferr_cnt;

    // Reference model and master buffers
    logic [7:0] model_regs [16];
    logic [7:0] tx_buf [16];
    logic [7:0] rx_buf [16];
    logic [7:0] rx_cmd;
    bit         oe_ok;

    spi_burst_reg_slave #(.DATA_W(8), .ADDR_W(4), .SYNC_STAGES(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .spi_mode_i   (spi_mode),
        .sclk_i       (sclk),
        .ss_n_i       (ss_n),
        .mosi_i       (mosi),
        .miso_o       (miso),
        .miso_oe_o    (miso_oe),
        .reg_wr_en_o  (reg_wr_en),
        .reg_wr_addr_o(reg_wr_addr),
        .reg_wr_data_o(reg_wr_data),
        .reg_rd_addr_o(reg_rd_addr),
        .reg_rd_data_i(reg_rd_data),
        .busy_o       (busy),
        .frame_err_o  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign reg_rd_data = regfile[reg_rd_addr];

    // Register file updated by DUT write strobes; logs every write and error pulse cycle
    always @(posedge clk) begin
        if (!rf_init_q) begin
            for (int i = 0; i < 16; i++) regfile[i] <= 8'h00;
            rf_init_q <= 1'b1;
        end else if (reg_wr_en === 1'b1) begin
            regfile[reg_wr_addr] <= reg_wr_data;
            wr_q.push_back({reg_wr_addr, reg_wr_data});
        end
        if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    end

    task automatic begin_frame(input logic [1:0] mode);
        @(negedge clk);
        ss_n     = 1'b1;
        spi_mode = mode;
        sclk     = mode[1];
        repeat (10) @(negedge clk);
        ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic end_frame();
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Master shifts out the top nbits of tx, MSB first, and collects miso
    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!spi_mode[0]) begin
                mosi = tx[7-i];
                repeat (HALF) @(negedge clk);
                rx   = {rx[6:0], miso};
                if (miso_oe !== 1'b1) oe_ok = 1'b0;
                sclk = ~spi_mode[1];
                repeat (HALF) @(negedge clk);
                sclk = spi_mode[1];
            end else begin
                sclk = ~spi_mode[1];
                mosi = tx[7-i];
                repeat (HALF) @(negedge clk);
                rx   = {rx[6:0], miso};
                if (miso_oe !== 1'b1) oe_ok = 1'b0;
                sclk = spi_mode[1];
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic run_frame(input logic [1:0] mode, input logic [7:0] cmd, input int nw);
        oe_ok = 1'b1;
        begin_frame(mode);
        xfer_bits(cmd, 8, rx_cmd);
        for (int k = 0; k < nw; k++) xfer_bits(tx_buf[k], 8, rx_buf[k]);
        end_frame();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({miso, miso_oe, reg_wr_en, busy, frame_err} !== 5'b0)
            $display("FAIL reset_ctrl: got %b, expected 00000",
                     {miso, miso_oe, reg_wr_en, busy, frame_err});
        else n_pass++;
        n_checks++;
        if ({reg_wr_addr, reg_wr_data, reg_rd_addr} !== 16'h0)
            $display("FAIL reset_bus: got %h, expected 0000", {reg_wr_addr, reg_wr_data, reg_rd_addr});
        else n_pass++;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_write_mode0();
        int base = wr_q.size();
        int ferr0 = ferr_cnt;
        tx_buf[0] = 8'h12;
        run_frame(2'b00, 8'h03, 1);
        model_regs[3] = 8'h12;
        n_checks++;
        if (wr_q.size() - base != 1) $display("FAIL wr0_count: got %0d, expected 1", wr_q.size() - base);
        else n_pass++;
        n_checks++;
        if (wr_q.size() <= base || wr_q[base] !== 12'h312)
            $display("FAIL wr0_entry: got %h, expected 312", (wr_q.size() > base) ? wr_q[base] : 12'hxxx);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || ferr_cnt != ferr0)
            $display("FAIL wr0_end: got busy=%b errs=%0d, expected busy=0 errs=0", busy, ferr_cnt - ferr0);
        else n_pass++;
    endtask

    task automatic test_read_mode0();
        int base = wr_q.size();
        tx_buf[0] = 8'hFF;
        run_frame(2'b00, 8'h83, 1);
        n_checks++;
        if (rx_buf[0] !== model_regs[3])
            $display("FAIL rd0_data: got %h, expected %h", rx_buf[0], model_regs[3]);
        else n_pass++;
        n_checks++;
        if (rx_cmd !== 8'h00) $display("FAIL rd0_cmd_miso: got %h, expected 00", rx_cmd);
        else n_pass++;
        n_checks++;
        if (oe_ok !== 1'b1 || miso_oe !== 1'b0 || miso !== 1'b0)
            $display("FAIL rd0_oe: got in_frame_ok=%b after=%b miso=%b, expected 1 0 0", oe_ok, miso_oe, miso);
        else n_pass++;
        n_checks++;
        if (wr_q.size() != base) $display("FAIL rd0_nowrite: got %0d writes, expected 0", wr_q.size() - base);
        else n_pass++;
    endtask

    task automatic test_burst_wrap();
        int base = wr_q.size();
        logic [11:0] exp;
        tx_buf[0] = 8'hA1; tx_buf[1] = 8'hB2; tx_buf[2] = 8'hC3;
        run_frame(2'b11, 8'h0E, 3);
        for (int k = 0; k < 3; k++) model_regs[4'(14 + k)] = tx_buf[k];
        n_checks++;
        if (wr_q.size() - base != 3) $display("FAIL burst_count: got %0d, expected 3", wr_q.size() - base);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            exp = {4'(14 + k), tx_buf[k]};
            n_checks++;
            if (wr_q.size() <= base + k || wr_q[base + k] !== exp)
                $display("FAIL burst_wr%0d: got %h, expected %h", k,
                         (wr_q.size() > base + k) ? wr_q[base + k] : 12'hxxx, exp);
            else n_pass++;
        end
        run_frame(2'b11, 8'h8E, 3);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rx_buf[k] !== model_regs[4'(14 + k)])
                $display("FAIL burst_rd%0d: got %h, expected %h", k, rx_buf[k], model_regs[4'(14 + k)]);
            else n_pass++;
        end
    endtask

    task automatic test_modes_1_2();
        for (int m = 1; m <= 2; m++) begin
            int base = wr_q.size();
            tx_buf[0] = 8'h5A;
            run_frame(2'(m), 8'h07, 1);
            model_regs[7] = 8'h5A;
            n_checks++;
            if (wr_q.size() - base != 1 || wr_q[base] !== 12'h75A)
                $display("FAIL mode%0d_wr: got %0d writes first=%h, expected 1 write 75a", m,
                         wr_q.size() - base, (wr_q.size() > base) ? wr_q[base] : 12'hxxx);
            else n_pass++;
            tx_buf[0] = 8'h00;
            run_frame(2'(m), 8'h87, 1);
            n_checks++;
            if (rx_buf[0] !== model_regs[7]) $display("FAIL mode%0d_rd: got %h, expected %h", m, rx_buf[0], model_regs[7]);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        int base = wr_q.size();
        int ferr0 = ferr_cnt;
        logic [7:0] dummy;
        oe_ok = 1'b1;
        begin_frame(2'b00);
        xfer_bits(8'h09, 8, dummy);
        xfer_bits(8'hE7, 5, dummy);
        end_frame();
        n_checks++;
        if (wr_q.size() != base) $display("FAIL abort_nowrite: got %0d writes, expected 0", wr_q.size() - base);
        else n_pass++;
        n_checks++;
        if (ferr_cnt - ferr0 != 1) $display("FAIL abort_err: got %0d err cycles, expected 1", ferr_cnt - ferr0);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || miso_oe !== 1'b0)
            $display("FAIL abort_idle: got busy=%b oe=%b, expected 0 0", busy, miso_oe);
        else n_pass++;
        tx_buf[0] = 8'h33;
        run_frame(2'b00, 8'h01, 1);
        model_regs[1] = 8'h33;
        n_checks++;
        if (wr_q.size() - base != 1 || wr_q[base] !== 12'h133 || ferr_cnt - ferr0 != 1)
            $display("FAIL abort_recover: got %0d writes first=%h errs=%0d, expected 1 write 133 errs=1",
                     wr_q.size() - base, (wr_q.size() > base) ? wr_q[base] : 12'hxxx, ferr_cnt - ferr0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int base = wr_q.size();
        logic [7:0] dummy;
        oe_ok = 1'b1;
        begin_frame(2'b00);
        xfer_bits(8'h0A, 3, dummy);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({miso, miso_oe, reg_wr_en, busy, frame_err, reg_wr_addr, reg_wr_data, reg_rd_addr} !== 21'h0)
            $display("FAIL midrst_outputs: got %h, expected 000000",
                     {miso, miso_oe, reg_wr_en, busy, frame_err, reg_wr_addr, reg_wr_data, reg_rd_addr});
        else n_pass++;
        xfer_bits(8'h50, 5, dummy);
        xfer_bits(8'h99, 8, dummy);
        xfer_bits(8'h77, 8, dummy);
        n_checks++;
        if (wr_q.size() != base || busy !== 1'b0)
            $display("FAIL midrst_ignored: got %0d writes busy=%b, expected 0 writes busy=0",
                     wr_q.size() - base, busy);
        else n_pass++;
        end_frame();
        tx_buf[0] = 8'h44;
        run_frame(2'b00, 8'h02, 1);
        model_regs[2] = 8'h44;
        n_checks++;
        if (wr_q.size() - base != 1 || wr_q[base] !== 12'h244)
            $display("FAIL midrst_recover: got %0d writes first=%h, expected 1 write 244",
                     wr_q.size() - base, (wr_q.size() > base) ? wr_q[base] : 12'hxxx);
        else n_pass++;
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 8; f++) begin
            logic [1:0] mode = 2'($urandom_range(0, 3));
            logic       rw   = 1'($urandom_range(0, 1));
            logic [3:0] a    = 4'($urandom_range(0, 15));
            int         n    = $urandom_range(1, 4);
            int         base = wr_q.size();
            for (int k = 0; k < n; k++) tx_buf[k] = 8'($urandom);
            run_frame(mode, {rw, 3'($urandom), a}, n);
            if (!rw) begin
                n_checks++;
                if (wr_q.size() - base != n)
                    $display("FAIL rnd%0d_wcount: got %0d, expected %0d", f, wr_q.size() - base, n);
                else n_pass++;
                for (int k = 0; k < n; k++) begin
                    logic [11:0] exp = {4'(a + k), tx_buf[k]};
                    model_regs[4'(a + k)] = tx_buf[k];
                    n_checks++;
                    if (wr_q.size() <= base + k || wr_q[base + k] !== exp)
                        $display("FAIL rnd%0d_wr%0d: got %h, expected %h", f, k,
                                 (wr_q.size() > base + k) ? wr_q[base + k] : 12'hxxx, exp);
                    else n_pass++;
                end
            end else begin
                n_checks++;
                if (wr_q.size() != base)
                    $display("FAIL rnd%0d_nowrite: got %0d writes, expected 0", f, wr_q.size() - base);
                else n_pass++;
                for (int k = 0; k < n; k++) begin
                    n_checks++;
                    if (rx_buf[k] !== model_regs[4'(a + k)])
                        $display("FAIL rnd%0d_rd%0d: got %h, expected %h", f, k, rx_buf[k],
                                 model_regs[4'(a + k)]);
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        spi_mode = 2'b00;
        sclk     = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        test_reset();
        test_write_mode0();
        test_read_mode0();
        test_burst_wrap();
        test_modes_1_2();
        test_abort();
        test_reset_mid_frame();
        test_random_frames();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
